// File: rtl/gact_ref_loader_pkg.sv
// Shared types and constants for the GACT reference loader.
package gact_ref_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EMIT  = 3'd2,
    PAD   = 3'd3,
    FIN   = 3'd4
  } state_e;

  // 'N' maps to zero substitution scores in Ascii2Param; gap params are kept.
  localparam logic [7:0] PAD_CHAR = 8'h4E;

  function automatic int pe_idx_w(input int num_pe);
    return $clog2(num_pe);
  endfunction

endpackage

// File: rtl/gact_ref_loader_if.sv
// Word-in / base-out stream bundle between the tile fetch path, the loader and the PE array.
interface gact_ref_loader_if
  import gact_ref_loader_pkg::*;
#(
  parameter int NUM_PE     = 32,
  parameter int WORD_BYTES = 4
) ();

  localparam int PIW = pe_idx_w(NUM_PE);

  logic [8*WORD_BYTES-1:0] in_word;
  logic                    in_word_valid;
  logic                    in_word_ready;
  logic [7:0]              char_out;
  logic                    char_valid;
  logic                    char_ready;
  logic [PIW-1:0]          char_pe_idx;
  logic                    char_last;

  // Loader side.
  modport master (
    input  in_word, in_word_valid, char_ready,
    output in_word_ready, char_out, char_valid, char_pe_idx, char_last
  );

  // Fetch path / PE array side.
  modport slave (
    output in_word, in_word_valid, char_ready,
    input  in_word_ready, char_out, char_valid, char_pe_idx, char_last
  );

endinterface

// File: rtl/gact_ref_loader_unpacker.sv
// Holds the current packed word and walks a byte pointer across it, byte 0 first.
module gact_word_unpacker #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    advance,
  input  logic [8*WORD_BYTES-1:0] in_word,
  output logic [7:0]              cur_byte,
  output logic                    last_byte
);

  localparam int BIW = $clog2(WORD_BYTES);

  logic [8*WORD_BYTES-1:0] word_q;
  logic [BIW-1:0]          byte_idx;

  // Load wins over advance so a back-to-back refill restarts cleanly at byte 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      byte_idx <= '0;
    end else if (load) begin
      word_q   <= in_word;
      byte_idx <= '0;
    end else if (advance) begin
      byte_idx <= byte_idx + 1'b1;
    end
  end

  assign cur_byte  = word_q[{byte_idx, 3'b000} +: 8];
  assign last_byte = (byte_idx == BIW'(WORD_BYTES - 1));

endmodule

// File: rtl/gact_ref_loader.sv
// Streams one tile's reference bases to the PE array, padding the final block with 'N'.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | requesting a packed word, no base on the output
// EMIT  | presenting buffered reference bytes one per handshake
// PAD   | presenting 'N' until the current block is full
// FIN   | one-cycle done pulse
module gact_ref_loader
  import gact_ref_loader_pkg::*;
#(
  parameter int PE_WIDTH   = 10,
  parameter int NUM_PE     = 32,
  parameter int LEN_WIDTH  = 10,
  parameter int WORD_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] ref_len,
  gact_ref_loader_if.master    bus,
  output logic                 busy,
  output logic                 done
);

  localparam int             PIW     = pe_idx_w(NUM_PE);
  localparam logic [PIW-1:0] PE_LAST = PIW'(NUM_PE - 1);

  if (PE_WIDTH < 1) begin : g_bad_pe_width
    $error("PE_WIDTH must be positive");
  end
  if (NUM_PE < 2 || (NUM_PE & (NUM_PE - 1)) != 0) begin : g_bad_num_pe
    $error("NUM_PE must be a power of 2 and at least 2");
  end
  if (WORD_BYTES < 2 || (WORD_BYTES & (WORD_BYTES - 1)) != 0) begin : g_bad_word_bytes
    $error("WORD_BYTES must be a power of 2 and at least 2");
  end

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, sent_q, sent_inc;
  logic [PIW-1:0]       pe_idx_q;
  logic                 word_load, byte_advance, char_hs, tile_end;
  logic [7:0]           cur_byte;
  logic                 last_byte;

  assign sent_inc     = sent_q + 1'b1;
  assign tile_end     = (sent_inc == len_q);
  assign char_hs      = bus.char_valid && bus.char_ready;
  assign word_load    = bus.in_word_valid && bus.in_word_ready;
  assign byte_advance = (state_q == EMIT) && bus.char_ready;

  gact_word_unpacker #(
    .WORD_BYTES (WORD_BYTES)
  ) u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (word_load),
    .advance   (byte_advance),
    .in_word   (bus.in_word),
    .cur_byte  (cur_byte),
    .last_byte (last_byte)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Tile length latch, sent-base counter and PE index (wraps per block).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      sent_q   <= '0;
      pe_idx_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        len_q    <= ref_len;
        sent_q   <= '0;
        pe_idx_q <= '0;
      end
      if (char_hs) pe_idx_q <= pe_idx_q + 1'b1;
      if (char_hs && state_q == EMIT) sent_q <= sent_inc;
    end
  end

  // Next state and handshake outputs; the EMIT refill ready is combinational from char_ready.
  always_comb begin
    state_d           = state_q;
    bus.in_word_ready = 1'b0;
    bus.char_valid    = 1'b0;
    bus.char_out      = 8'h00;
    busy              = 1'b0;
    done              = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (ref_len != '0) ? FETCH : FIN;
      end
      FETCH: begin
        busy              = 1'b1;
        bus.in_word_ready = 1'b1;
        if (bus.in_word_valid) state_d = EMIT;
      end
      EMIT: begin
        busy           = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_out   = cur_byte;
        if (bus.char_ready) begin
          if (tile_end) begin
            state_d = (pe_idx_q != PE_LAST) ? PAD : FIN;
          end else if (last_byte) begin
            bus.in_word_ready = 1'b1;
            state_d           = bus.in_word_valid ? EMIT : FETCH;
          end
        end
      end
      PAD: begin
        busy           = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_out   = PAD_CHAR;
        if (bus.char_ready && pe_idx_q == PE_LAST) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.char_pe_idx = pe_idx_q;
  assign bus.char_last   = bus.char_valid && (pe_idx_q == PE_LAST);

endmodule

// File: tb/tb_gact_ref_loader.sv
// Randomized self-checking bench for gact_ref_loader against a stream-level model.
module tb_gact_ref_loader;

  localparam int NP = 4;
  localparam int WB = 4;
  localparam int LW = 10;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] ref_len = '0;
  logic          busy, done;

  gact_ref_loader_if #(.NUM_PE(NP), .WORD_BYTES(WB)) bus ();

  gact_ref_loader #(
    .PE_WIDTH   (PW),
    .NUM_PE     (NP),
    .LEN_WIDTH  (LW),
    .WORD_BYTES (WB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ref_len (ref_len),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tb_bytes[$];
  logic [7:0] acgt[4] = '{8'h41, 8'h43, 8'h47, 8'h54};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_bases(input string s);
    tb_bytes.delete();
    for (int i = 0; i < s.len(); i++) tb_bytes.push_back(s[i]);
  endtask

  task automatic rand_bases(input int n);
    tb_bytes.delete();
    for (int i = 0; i < n; i++) tb_bytes.push_back(acgt[$urandom_range(0, 3)]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cv"},   bus.char_valid, 0);
    chk({tag, "_iwr"},  bus.in_word_ready, 0);
    chk({tag, "_char"}, bus.char_out, 0);
    chk({tag, "_pe"},   bus.char_pe_idx, 0);
    chk({tag, "_last"}, bus.char_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // rmode: 0 always ready, 1 toggling 1,0,..., 2 random. wgap: random word-valid gaps.
  // poke: spurious start and word-valid while not wanted. abort_after: reset after that many bases.
  task automatic run_tile(input int len, input int rmode, input bit wgap, input bit poke,
                          input int abort_after, input string name);
    int nwords, total, widx, wcount, cyc, done_cyc, last_hs_cyc, lim;
    bit saw_iwr, saw_cv, prev_stall;
    logic [7:0] p_ch, exp_ch;
    logic [1:0] p_pe;
    logic p_last;
    logic [8*WB-1:0] w;
    logic [7:0] gch[$];
    int gpe[$];
    bit glast[$];
    logic [8*WB-1:0] words[$];

    nwords = (len + WB - 1) / WB;
    total  = ((len + NP - 1) / NP) * NP;
    while (tb_bytes.size() < nwords * WB) tb_bytes.push_back(8'h78);
    for (int wi = 0; wi < nwords; wi++) begin
      w = '0;
      for (int k = 0; k < WB; k++) w[8*k +: 8] = tb_bytes[wi*WB + k];
      words.push_back(w);
    end

    widx = 0; wcount = 0; cyc = 0; done_cyc = -1; last_hs_cyc = -1;
    saw_iwr = 0; saw_cv = 0; prev_stall = 0;
    p_ch = '0; p_pe = '0; p_last = 0;

    @(negedge clk);
    start = 1'b1;
    ref_len = LW'(len);
    @(negedge clk);
    start = 1'b0;

    while (done_cyc < 0 && cyc < 2000) begin
      case (rmode)
        0:       bus.char_ready = 1'b1;
        1:       bus.char_ready = ((cyc % 2) == 0);
        default: bus.char_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (widx < nwords) begin
        bus.in_word_valid = wgap ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.in_word = words[widx];
      end else begin
        bus.in_word_valid = poke;
        bus.in_word = $urandom;
      end
      if (poke) begin
        start = ($urandom_range(0, 3) == 0);
        ref_len = LW'($urandom);
      end
      #1;
      if (bus.in_word_ready) saw_iwr = 1;
      if (bus.char_valid) saw_cv = 1;
      if (prev_stall) begin
        chk($sformatf("%s_hold_valid_c%0d", name, cyc), bus.char_valid, 1);
        chk($sformatf("%s_hold_char_c%0d", name, cyc), bus.char_out, p_ch);
        chk($sformatf("%s_hold_pe_c%0d", name, cyc), bus.char_pe_idx, p_pe);
        chk($sformatf("%s_hold_last_c%0d", name, cyc), bus.char_last, p_last);
      end
      prev_stall = bus.char_valid && !bus.char_ready;
      p_ch = bus.char_out; p_pe = bus.char_pe_idx; p_last = bus.char_last;
      if (bus.char_valid && bus.char_ready) begin
        gch.push_back(bus.char_out);
        gpe.push_back(int'(bus.char_pe_idx));
        glast.push_back(bus.char_last);
        last_hs_cyc = cyc;
      end
      if (bus.in_word_valid && bus.in_word_ready) begin
        wcount++;
        if (widx < nwords) widx++;
      end
      if (done) done_cyc = cyc;
      if (abort_after > 0 && gch.size() == abort_after) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero({name, "_rst"});
        @(negedge clk);
        start = 1'b0;
        bus.in_word_valid = 1'b0;
        bus.char_ready = 1'b0;
        rst_n = 1'b1;
        tb_bytes.delete();
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bus.in_word_valid = 1'b0;
    #1;

    chk({name, "_done_seen"}, (done_cyc >= 0), 1);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_count"}, gch.size(), total);
    chk({name, "_words"}, wcount, nwords);
    lim = (gch.size() < total) ? gch.size() : total;
    for (int i = 0; i < lim; i++) begin
      exp_ch = (i < len) ? tb_bytes[i] : 8'h4E;
      chk($sformatf("%s_char%0d", name, i), gch[i], exp_ch);
      chk($sformatf("%s_pe%0d", name, i), gpe[i], i % NP);
      chk($sformatf("%s_last%0d", name, i), glast[i], ((i % NP) == NP - 1));
    end
    if (rmode == 0 && !wgap) chk({name, "_done_cyc"}, done_cyc, (len == 0) ? 0 : total + 1);
    else if (len > 0) chk({name, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
    if (len == 0) begin
      chk({name, "_no_iwr"}, saw_iwr, 0);
      chk({name, "_no_cv"}, saw_cv, 0);
    end
    tb_bytes.delete();
  endtask

  initial begin
    bus.in_word = '0;
    bus.in_word_valid = 1'b0;
    bus.char_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    set_bases("ACGTTGCA");
    run_tile(8, 0, 0, 0, 0, "t1");
    set_bases("ACGTGGxx");
    run_tile(6, 0, 0, 0, 0, "t2");
    set_bases("ACGTG");
    run_tile(5, 1, 0, 0, 0, "t3");
    tb_bytes.delete();
    run_tile(0, 0, 0, 0, 0, "t4");
    rand_bases(8);
    run_tile(8, 0, 0, 0, 3, "t5");
    rand_bases(4);
    run_tile(4, 0, 0, 0, 0, "t5b");
    rand_bases(7);
    run_tile(7, 0, 0, 1, 0, "t6");

    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(0, 40);
      rand_bases(len);
      run_tile(len, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
               $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
